// File: rtl/iob_ext_mem_arb.sv
// iob_ext_mem_arb: N-master native-bus arbiter to L2 with read-routing FIFO and invalidate sequencer.
// Grant and return paths are combinational; only pointer, lock, FIFO, FSM and error are registered.
module iob_ext_mem_arb #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int OUTST_W   = 2,
   parameter int PRIO_MODE = 0
) (
   input  logic                          clk_i,
   input  logic                          arst_n_i,
   input  logic                          cke_i,
   input  logic [N_MASTERS-1:0]          m_avalid_i,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
   output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
   output logic [N_MASTERS-1:0]          m_rvalid_o,
   output logic [N_MASTERS-1:0]          m_ready_o,
   output logic                          s_avalid_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic [DATA_W-1:0]             s_wdata_o,
   output logic [DATA_W/8-1:0]           s_wstrb_o,
   input  logic [DATA_W-1:0]             s_rdata_i,
   input  logic                          s_rvalid_i,
   input  logic                          s_ready_i,
   input  logic                          inv_req_i,
   input  logic                          wtb_empty_i,
   output logic                          inv_o,
   output logic                          inv_busy_o,
   output logic                          err_o
);
   localparam int SW    = DATA_W / 8;
   localparam int PW    = $clog2(N_MASTERS);
   localparam int DEPTH = 2 ** OUTST_W;

   typedef enum logic [1:0] {IDLE, DRAIN, INV} state_t;

   state_t               r_state;
   logic [PW-1:0]        r_ptr, r_lock_g, w_g;
   logic [PW-1:0]        r_mem [DEPTH];
   logic [OUTST_W-1:0]   r_wp, r_rp;
   logic [OUTST_W:0]     r_cnt;
   logic                 r_lock, r_inv, r_busy, r_err;
   logic                 w_gv, w_acc, w_push, w_pop, w_empty, w_full;
   logic [N_MASTERS-1:0] w_rd, w_elig;
   int                   w_idx;

   for (genvar k = 0; k < N_MASTERS; k++) begin : g_m
      assign w_rd[k] = ~|m_wstrb_i[k*SW +: SW];
      assign m_rdata_o[k*DATA_W +: DATA_W] = s_rdata_i;
   end

   assign w_empty = r_cnt == '0;
   assign w_full  = r_cnt == (OUTST_W+1)'(DEPTH);
   // Reads are held off while the routing FIFO is full; nothing new is granted while invalidating.
   assign w_elig  = m_avalid_i & ~(w_rd & {N_MASTERS{w_full}}) & {N_MASTERS{r_state == IDLE}};

   always_comb begin
      w_g   = r_lock_g;
      w_gv  = r_lock;
      w_idx = 0;
      if (!r_lock)
         for (int i = 0; i < N_MASTERS; i++) begin
            w_idx = (PRIO_MODE != 0) ? i : (int'(r_ptr) + i) % N_MASTERS;
            if (!w_gv && w_elig[w_idx]) begin
               w_gv = 1'b1;
               w_g  = PW'(w_idx);
            end
         end
   end

   assign s_avalid_o = w_gv & m_avalid_i[w_g];
   assign s_addr_o   = m_addr_i[w_g*ADDR_W +: ADDR_W];
   assign s_wdata_o  = m_wdata_i[w_g*DATA_W +: DATA_W];
   assign s_wstrb_o  = m_wstrb_i[w_g*SW +: SW];
   assign m_ready_o  = s_avalid_o ? ({{(N_MASTERS-1){1'b0}}, s_ready_i} << w_g) : '0;
   assign w_acc      = s_avalid_o & s_ready_i;
   assign w_push     = w_acc & w_rd[w_g];
   assign w_pop      = s_rvalid_i & ~w_empty;
   assign m_rvalid_o = w_pop ? ({{(N_MASTERS-1){1'b0}}, 1'b1} << r_mem[r_rp]) : '0;
   assign inv_o      = r_inv;
   assign inv_busy_o = r_busy;
   assign err_o      = r_err;

   always_ff @(posedge clk_i)
      if (cke_i && w_push) r_mem[r_wp] <= w_g;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_lock   <= 1'b0;
         r_lock_g <= '0;
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_inv    <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else if (cke_i) begin
         if (w_acc && PRIO_MODE == 0) r_ptr <= (w_g == PW'(N_MASTERS-1)) ? '0 : w_g + 1'b1;
         r_lock   <= s_avalid_o & ~s_ready_i;
         r_lock_g <= w_g;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt    <= r_cnt + (OUTST_W+1)'(w_push) - (OUTST_W+1)'(w_pop);
         if (s_rvalid_i && w_empty) r_err <= 1'b1;
         case (r_state)
            IDLE:
               if (inv_req_i) begin
                  r_state <= DRAIN;
                  r_busy  <= 1'b1;
               end
            DRAIN:
               if (w_empty && !r_lock && wtb_empty_i) begin
                  r_state <= INV;
                  r_inv   <= 1'b1;
               end
            INV: begin
               r_state <= IDLE;
               r_inv   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iob_ext_mem_arb.sv
// tb_iob_ext_mem_arb: directed checks of a round-robin (depth-2 FIFO) and a fixed-priority arbiter.
module tb_iob_ext_mem_arb;
   logic        clk = 1'b0, rst_n, cke, s_rvalid, s_ready, inv_req, wtb_empty;
   logic [2:0]  av;
   logic [95:0] addr, wdata;
   logic [11:0] wstrb;
   logic [31:0] s_rdata;
   logic [95:0] rr_rdata, fp_rdata;
   logic [2:0]  rr_rvalid, rr_ready, fp_rvalid, fp_ready;
   logic        rr_sav, fp_sav, rr_inv, fp_inv, rr_busy, fp_busy, rr_err, fp_err;
   logic [31:0] rr_saddr, fp_saddr, rr_swdata, fp_swdata;
   logic [3:0]  rr_swstrb, fp_swstrb;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   iob_ext_mem_arb #(.N_MASTERS(3), .OUTST_W(1), .PRIO_MODE(0)) u_rr (
      .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .m_avalid_i(av), .m_addr_i(addr),
      .m_wdata_i(wdata), .m_wstrb_i(wstrb), .m_rdata_o(rr_rdata), .m_rvalid_o(rr_rvalid),
      .m_ready_o(rr_ready), .s_avalid_o(rr_sav), .s_addr_o(rr_saddr), .s_wdata_o(rr_swdata),
      .s_wstrb_o(rr_swstrb), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready),
      .inv_req_i(inv_req), .wtb_empty_i(wtb_empty), .inv_o(rr_inv), .inv_busy_o(rr_busy),
      .err_o(rr_err));

   iob_ext_mem_arb #(.N_MASTERS(3), .OUTST_W(2), .PRIO_MODE(1)) u_fp (
      .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .m_avalid_i(av), .m_addr_i(addr),
      .m_wdata_i(wdata), .m_wstrb_i(wstrb), .m_rdata_o(fp_rdata), .m_rvalid_o(fp_rvalid),
      .m_ready_o(fp_ready), .s_avalid_o(fp_sav), .s_addr_o(fp_saddr), .s_wdata_o(fp_swdata),
      .s_wstrb_o(fp_swstrb), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready),
      .inv_req_i(inv_req), .wtb_empty_i(wtb_empty), .inv_o(fp_inv), .inv_busy_o(fp_busy),
      .err_o(fp_err));

   task automatic mreq(input int k, input logic v, input logic wr);
      av[k] = v;
      wstrb[k*4 +: 4] = wr ? 4'hF : 4'h0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cke = 1'b1; av = '0; wstrb = '0; s_rvalid = 1'b0; s_ready = 1'b1;
      inv_req = 1'b0; wtb_empty = 1'b1; s_rdata = '0;
      for (int k = 0; k < 3; k++) begin
         addr[k*32 +: 32]  = 32'h1000 * (k + 1);
         wdata[k*32 +: 32] = 32'hD000 + k;
      end
      #1;
      checks++;
      if ({rr_sav, rr_ready, rr_rvalid, rr_inv, rr_busy, rr_err} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs got sav=%b ready=%b rvalid=%b inv=%b busy=%b err=%b want all 0",
                  rr_sav, rr_ready, rr_rvalid, rr_inv, rr_busy, rr_err);
      end
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      logic [31:0] ea [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h1000};
      step();
      for (int k = 0; k < 3; k++) mreq(k, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (rr_ready !== exp[c] || rr_saddr !== ea[c] || rr_swstrb !== 4'hF) begin
            errors++;
            $display("FAIL rr_grant%0d got ready=%b addr=%h strb=%h want ready=%b addr=%h strb=f",
                     c, rr_ready, rr_saddr, rr_swstrb, exp[c], ea[c]);
         end
         step();
      end
      av = '0;
   endtask

   task automatic test_fixed_priority();
      mreq(0, 1'b1, 1'b1); mreq(2, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (fp_ready !== 3'b001 || fp_swdata !== 32'hD000) begin
            errors++;
            $display("FAIL fp_grant%0d got ready=%b wdata=%h want ready=001 wdata=0000d000",
                     c, fp_ready, fp_swdata);
         end
         step();
      end
      av = '0;
   endtask

   task automatic test_pipelined_reads();
      step();
      mreq(1, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b010) begin errors++; $display("FAIL rd_m1_accept got %b want 010", rr_ready); end
      step(); mreq(1, 1'b0, 1'b0); mreq(0, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b001) begin errors++; $display("FAIL rd_m0_accept got %b want 001", rr_ready); end
      step(); av = '0; s_rvalid = 1'b1; s_rdata = 32'hA5A5A5A5; #1;
      checks++;
      if (rr_rvalid !== 3'b010 || rr_rdata[63:32] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL rd_ret1 got rvalid=%b data=%h want 010 a5a5a5a5", rr_rvalid, rr_rdata[63:32]);
      end
      step(); s_rdata = 32'h5A5A5A5A; #1;
      checks++;
      if (rr_rvalid !== 3'b001 || rr_rdata[31:0] !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL rd_ret2 got rvalid=%b data=%h want 001 5a5a5a5a", rr_rvalid, rr_rdata[31:0]);
      end
      step(); s_rvalid = 1'b0; mreq(2, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b100) begin errors++; $display("FAIL rd_m2_accept got %b want 100", rr_ready); end
      step(); mreq(2, 1'b0, 1'b0); mreq(1, 1'b1, 1'b0); s_rvalid = 1'b1; s_rdata = 32'h11111111; #1;
      checks++;
      if (rr_rvalid !== 3'b100 || rr_ready !== 3'b010) begin
         errors++;
         $display("FAIL push_pop got rvalid=%b ready=%b want 100 010", rr_rvalid, rr_ready);
      end
      step(); av = '0; s_rdata = 32'h22222222; #1;
      checks++;
      if (rr_rvalid !== 3'b010 || rr_err !== 1'b0) begin
         errors++;
         $display("FAIL push_pop_ret got rvalid=%b err=%b want 010 0", rr_rvalid, rr_err);
      end
      step(); s_rvalid = 1'b0;
   endtask

   task automatic test_fifo_full();
      mreq(0, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b001) begin errors++; $display("FAIL full_rd0 got %b want 001", rr_ready); end
      step(); mreq(0, 1'b0, 1'b0); mreq(1, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b010) begin errors++; $display("FAIL full_rd1 got %b want 010", rr_ready); end
      step(); mreq(1, 1'b0, 1'b0); mreq(2, 1'b1, 1'b0); mreq(0, 1'b1, 1'b1); #1;
      checks++;
      if (rr_ready !== 3'b001) begin errors++; $display("FAIL full_write_pass got %b want 001", rr_ready); end
      step(); mreq(0, 1'b0, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b000 || rr_sav !== 1'b0) begin
         errors++;
         $display("FAIL full_rd_blocked got ready=%b sav=%b want 000 0", rr_ready, rr_sav);
      end
      step(); s_rvalid = 1'b1; #1;
      checks++;
      if (rr_rvalid !== 3'b001) begin errors++; $display("FAIL full_pop got %b want 001", rr_rvalid); end
      step(); s_rvalid = 1'b0; #1;
      checks++;
      if (rr_ready !== 3'b100) begin errors++; $display("FAIL full_rd2_accept got %b want 100", rr_ready); end
      step(); av = '0; s_rvalid = 1'b1; #1;
      checks++;
      if (rr_rvalid !== 3'b010) begin errors++; $display("FAIL full_drain1 got %b want 010", rr_rvalid); end
      step(); #1;
      checks++;
      if (rr_rvalid !== 3'b100) begin errors++; $display("FAIL full_drain2 got %b want 100", rr_rvalid); end
      step(); s_rvalid = 1'b0;
   endtask

   task automatic test_lock_invalidate();
      wtb_empty = 1'b0; s_ready = 1'b0; inv_req = 1'b1; mreq(1, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b000 || rr_sav !== 1'b1 || rr_saddr !== 32'h2000) begin
         errors++;
         $display("FAIL lock_c0 got ready=%b sav=%b addr=%h want 000 1 00002000", rr_ready, rr_sav, rr_saddr);
      end
      for (int c = 1; c < 3; c++) begin
         step(); inv_req = 1'b0; mreq(0, 1'b1, 1'b1); #1;
         checks++;
         if (rr_saddr !== 32'h2000 || rr_sav !== 1'b1 || rr_busy !== 1'b1 || rr_inv !== 1'b0) begin
            errors++;
            $display("FAIL lock_c%0d got addr=%h sav=%b busy=%b inv=%b want 00002000 1 1 0",
                     c, rr_saddr, rr_sav, rr_busy, rr_inv);
         end
      end
      step(); s_ready = 1'b1; #1;
      checks++;
      if (rr_ready !== 3'b010) begin errors++; $display("FAIL lock_accept got %b want 010", rr_ready); end
      step(); mreq(1, 1'b0, 1'b0); s_rvalid = 1'b1; #1;
      checks++;
      if (rr_sav !== 1'b0 || rr_rvalid !== 3'b010 || rr_inv !== 1'b0) begin
         errors++;
         $display("FAIL drain_block got sav=%b rvalid=%b inv=%b want 0 010 0", rr_sav, rr_rvalid, rr_inv);
      end
      step(); s_rvalid = 1'b0; step(); #1;
      checks++;
      if (rr_inv !== 1'b0 || rr_busy !== 1'b1) begin
         errors++;
         $display("FAIL wait_wtb got inv=%b busy=%b want 0 1", rr_inv, rr_busy);
      end
      wtb_empty = 1'b1;
      step(); #1;
      checks++;
      if (rr_inv !== 1'b1 || rr_busy !== 1'b1) begin
         errors++;
         $display("FAIL inv_pulse got inv=%b busy=%b want 1 1", rr_inv, rr_busy);
      end
      step(); #1;
      checks++;
      if (rr_inv !== 1'b0 || rr_busy !== 1'b0 || rr_ready !== 3'b001) begin
         errors++;
         $display("FAIL inv_done got inv=%b busy=%b ready=%b want 0 0 001", rr_inv, rr_busy, rr_ready);
      end
      step(); av = '0;
   endtask

   task automatic test_stray_reset();
      s_rvalid = 1'b1; #1;
      checks++;
      if (rr_rvalid !== 3'b000) begin errors++; $display("FAIL stray_rvalid got %b want 000", rr_rvalid); end
      step(); s_rvalid = 1'b0; #1;
      checks++;
      if (rr_err !== 1'b1) begin errors++; $display("FAIL stray_err got %b want 1", rr_err); end
      step(); step(); #1;
      checks++;
      if (rr_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", rr_err); end
      mreq(0, 1'b1, 1'b0); #1;
      checks++;
      if (rr_ready !== 3'b001) begin errors++; $display("FAIL mid_rd_accept got %b want 001", rr_ready); end
      step(); av = '0; rst_n = 1'b0; #1;
      checks++;
      if ({rr_sav, rr_ready, rr_rvalid, rr_inv, rr_busy, rr_err} !== 10'b0) begin
         errors++;
         $display("FAIL mid_reset got sav=%b ready=%b rvalid=%b inv=%b busy=%b err=%b want all 0",
                  rr_sav, rr_ready, rr_rvalid, rr_inv, rr_busy, rr_err);
      end
      step(); rst_n = 1'b1; s_rvalid = 1'b1; #1;
      checks++;
      if (rr_rvalid !== 3'b000) begin errors++; $display("FAIL discarded_rd got %b want 000", rr_rvalid); end
      step(); s_rvalid = 1'b0; for (int k = 0; k < 3; k++) mreq(k, 1'b1, 1'b1); #1;
      checks++;
      if (rr_err !== 1'b1 || rr_ready !== 3'b001) begin
         errors++;
         $display("FAIL post_reset got err=%b ready=%b want 1 001", rr_err, rr_ready);
      end
      step(); av = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_pipelined_reads();
      test_fifo_full();
      test_lock_invalidate();
      test_stray_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
